// File: rtl/store_v.sv
//==============================================================================
// store_v : STORE unit, serialises packed tiles into byte-wide memory writes
// Option  : STORE_ZERO_PAD_EN pads a partial final tile out with 0x00 bytes
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module store_v #(
   parameter int DATA_WIDTH = 8,
   parameter int TILE_WIDTH = 128,
   parameter int ADDR_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  valid_in,
   input  logic [ADDR_WIDTH-1:0] dram_addr,
   input  logic [9:0]            length,
   output logic                  tile_ready,
   input  logic                  tile_valid,
   input  logic [TILE_WIDTH-1:0] tile_in,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_din,
   output logic                  busy,
   output logic                  done
);

   localparam int               TILE_ELEMS = TILE_WIDTH / DATA_WIDTH;
   localparam int               IDX_W      = $clog2(TILE_ELEMS) + 1;
   localparam logic [IDX_W-1:0] IDX_FULL   = IDX_W'(TILE_ELEMS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [9:0]              remaining;
   // Number of bytes of the current tile already issued to the write port
   logic [IDX_W-1:0]        elem_idx;
   logic [TILE_WIDTH-1:0]   tile_sr;
   logic                    take;
   logic                    tile_end;
   logic                    issue;
   logic [DATA_WIDTH-1:0]   next_byte;

   always_comb begin
      state_nxt  = state;
      tile_ready = (state == S_REQ);
      busy       = (state != S_IDLE);
      done       = (state == S_DONE);
      take       = tile_ready && tile_valid;
`ifdef STORE_ZERO_PAD_EN
      tile_end   = (elem_idx == IDX_FULL);
`else
      tile_end   = (elem_idx == IDX_FULL) || (remaining == '0);
`endif
      // The first byte comes straight off the handshake so writing starts the next cycle
      issue      = take || ((state == S_WRITE) && !tile_end);
      next_byte  = take ? tile_in[TILE_WIDTH-1 -: DATA_WIDTH]
                        : tile_sr[TILE_WIDTH-1 -: DATA_WIDTH];

      case (state)
         S_IDLE:  if (valid_in) state_nxt = (length == '0) ? S_DONE : S_REQ;
         S_REQ:   if (take) state_nxt = S_WRITE;
         S_WRITE: if (tile_end) state_nxt = (remaining == '0) ? S_DONE : S_REQ;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_addr   <= '0;
         remaining <= '0;
         elem_idx  <= '0;
         tile_sr   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
      end else begin
         mem_we <= issue;
         if ((state == S_IDLE) && valid_in) begin
            wr_addr   <= dram_addr;
            remaining <= length;
         end
         if (issue) begin
            mem_addr  <= wr_addr;
            wr_addr   <= wr_addr + ADDR_WIDTH'(1);
            remaining <= (remaining == '0) ? '0 : remaining - 10'd1;
            elem_idx  <= take ? IDX_W'(1) : elem_idx + IDX_W'(1);
            tile_sr   <= (take ? tile_in : tile_sr) << DATA_WIDTH;
`ifdef STORE_ZERO_PAD_EN
            mem_din   <= (remaining == '0) ? '0 : next_byte;
`else
            mem_din   <= next_byte;
`endif
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_store_v.sv
//==============================================================================
// tb_store_v : directed vector bench for store_v
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module tb_store_v;

`ifdef STORE_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic         clk;
   logic         reset_n;
   logic         valid_in;
   logic [23:0]  dram_addr;
   logic [9:0]   length;
   logic         tile_ready;
   logic         tile_valid;
   logic [127:0] tile_in;
   logic         mem_we;
   logic [23:0]  mem_addr;
   logic [7:0]   mem_din;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_fails  = 0;

   store_v dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .valid_in   (valid_in),
      .dram_addr  (dram_addr),
      .length     (length),
      .tile_ready (tile_ready),
      .tile_valid (tile_valid),
      .tile_in    (tile_in),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] base;
      logic [9:0]  len;
      logic [7:0]  seed;
      int          stall;
      bit          repulse;
      int          exp_wr;
      int          exp_done;
      int          exp_req;
      int          exp_first;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Tile t of a store carries bytes seed+16t, seed+16t+1, ... MSB-first
   function automatic logic [127:0] make_tile(input logic [7:0] first);
      logic [127:0] t;
      t = '0;
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = first + 8'(i);
      return t;
   endfunction

   task automatic run_store(input vec_t v, input string tag);
      int          cyc, nwr, ndone, nreq, first_wr, done_cyc, overlap, tiles, stall_left, late;
      bit          finished;
      logic [23:0] ea;
      logic [7:0]  ed;
      cyc = 0; nwr = 0; ndone = 0; nreq = 0; first_wr = -1; done_cyc = -1;
      overlap = 0; tiles = 0; stall_left = v.stall; finished = 1'b0; late = 0;
      dram_addr  = v.base;
      length     = v.len;
      valid_in   = 1'b1;
      tile_valid = 1'b1;
      tile_in    = make_tile(v.seed);
      while (!finished && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         valid_in = 1'b0;
         if (mem_we) begin
            if (first_wr < 0) first_wr = cyc;
            ea = v.base + 24'(nwr);
            ed = (nwr >= int'(v.len)) ? 8'h00 : v.seed + 8'(nwr);
            check({tag, " addr"}, 32'(mem_addr), 32'(ea));
            check({tag, " data"}, 32'(mem_din), 32'(ed));
            nwr++;
            if (v.repulse && nwr == 3) begin
               valid_in  = 1'b1;
               dram_addr = 24'hABCDEF;
               length    = 10'd7;
            end
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
            if (mem_we) overlap++;
            finished = 1'b1;
         end
         if (tile_ready) begin
            nreq++;
            if (stall_left > 0) begin
               tile_valid = 1'b0;
               stall_left--;
            end else begin
               tile_valid = 1'b1;
            end
            tile_in = make_tile(v.seed + 8'(16*tiles));
            if (tile_valid) tiles++;
         end else begin
            tile_valid = 1'b1;
         end
      end
      check({tag, " timeout"}, 32'(finished), 32'd1);
      check({tag, " writes"}, 32'(nwr), 32'(v.exp_wr));
      check({tag, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
      check({tag, " req_cycles"}, 32'(nreq), 32'(v.exp_req));
      check({tag, " first_write"}, 32'(first_wr), 32'(v.exp_first));
      check({tag, " done_we_overlap"}, 32'(overlap), 32'd0);
      // Must be back in IDLE and stay there: a pulse seen outside IDLE must not start a store
      repeat (3) begin
         @(posedge clk); #1;
         if (busy || done || mem_we || tile_ready) late++;
      end
      check({tag, " idle_after"}, 32'(late), 32'd0);
   endtask

   initial begin
      int   nwr, guard, bad;
      vec_t again;

      vecs[0] = '{24'h000100, 10'd16, 8'h00, 0, 1'b0, 16,              18,              1, 2};
      vecs[1] = '{24'h001000, 10'd20, 8'h40, 0, 1'b0, PAD ? 32 : 20,   PAD ? 35 : 23,   2, 2};
      vecs[2] = '{24'hFFFFF8, 10'd16, 8'hA0, 0, 1'b0, 16,              18,              1, 2};
      vecs[3] = '{24'h000200, 10'd1,  8'h11, 0, 1'b0, PAD ? 16 : 1,    PAD ? 18 : 3,    1, 2};
      vecs[4] = '{24'h123456, 10'd33, 8'h80, 0, 1'b0, PAD ? 48 : 33,   PAD ? 52 : 37,   3, 2};
      vecs[5] = '{24'h000777, 10'd0,  8'h55, 0, 1'b0, 0,               1,               0, -1};
      vecs[6] = '{24'h000300, 10'd16, 8'h20, 3, 1'b1, 16,              21,              4, 5};

      reset_n    = 1'b0;
      valid_in   = 1'b0;
      dram_addr  = '0;
      length     = '0;
      tile_valid = 1'b0;
      tile_in    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset tile_ready", 32'(tile_ready), 32'd0);
      check("reset mem_we", 32'(mem_we), 32'd0);
      check("reset mem_addr", 32'(mem_addr), 32'd0);
      check("reset mem_din", 32'(mem_din), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      reset_n = 1'b1;

      for (int k = 0; k < 7; k++) run_store(vecs[k], $sformatf("vec%0d", k));

      // Reset in the middle of a store, right after the 5th byte is on the port
      dram_addr  = 24'h000500;
      length     = 10'd16;
      tile_in    = make_tile(8'h50);
      tile_valid = 1'b1;
      valid_in   = 1'b1;
      nwr = 0; guard = 0; bad = 0;
      while (nwr < 5 && guard < 40) begin
         @(posedge clk); #1;
         valid_in = 1'b0;
         guard++;
         if (mem_we) nwr++;
      end
      check("midrst reached_5th", 32'(nwr), 32'd5);
      reset_n = 1'b0;
      #1;
      check("midrst mem_we", 32'(mem_we), 32'd0);
      check("midrst mem_addr", 32'(mem_addr), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst tile_ready", 32'(tile_ready), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         if (mem_we || done || busy) bad++;
      end
      check("midrst quiet", 32'(bad), 32'd0);
      reset_n = 1'b1;

      again = '{24'h000600, 10'd16, 8'hC0, 0, 1'b0, 16, 18, 1, 2};
      run_store(again, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/store_v.md
# store_v

Vector store unit for the tinyML accelerator: the write-side counterpart of the matrix/tile loader. It executes the STORE opcode (0x03). On a start pulse it requests packed tiles from the on-chip buffer side, serialises each tile into bytes, and writes them one byte per cycle into the byte-wide `simple_memory` port at consecutive DRAM addresses. It sits between the accelerator control FSM and the shared memory write port.

## Interface
Parameters:
- `DATA_WIDTH`, 8: element width in bits; must be 8, since the memory is byte-wide.
- `TILE_WIDTH`, 128: packed tile width in bits. `TILE_ELEMS = TILE_WIDTH/DATA_WIDTH` (16).
- `ADDR_WIDTH`, 24: DRAM byte-address width.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `valid_in`  in  1: one-cycle start pulse; sampled only in IDLE.
- `dram_addr`  in  ADDR_WIDTH: base byte address; captured with `valid_in`.
- `length`  in  10: number of elements to store (0..1023); captured with `valid_in`.
- `tile_ready`  out  1: the block can accept a tile this cycle.
- `tile_valid`  in  1: `tile_in` holds a valid tile.
- `tile_in`  in  TILE_WIDTH: packed tile. Element i is `tile_in[TILE_WIDTH-1-i*8 -: 8]` (MSB-first).
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  ADDR_WIDTH: memory byte address.
- `mem_din`  out  8: memory write data.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle completion pulse.

## Operation
- States: IDLE, REQ, WRITE, DONE.
- IDLE:
  - `valid_in`=1 latches `dram_addr` into `wr_addr` and `length` into `remaining`.
  - If `length`≠0, go to REQ; if `length`=0, go directly to DONE with no writes.
- REQ:
  - `tile_ready`=1 (combinational from state).
  - On `tile_ready && tile_valid`: latch `tile_in` into the shift register, set `elem_idx`=0, go to WRITE.
- WRITE:
  - Each cycle: `mem_we`=1, `mem_din`=tile element `elem_idx`, `mem_addr`=`wr_addr`.
  - Then `wr_addr`+=1, `remaining`-=1, `elem_idx`+=1.
  - Write count for a tile is `min(remaining, TILE_ELEMS)`.
  - After the last byte of a tile: if `remaining`>0 go to REQ, otherwise go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `valid_in` outside IDLE is ignored; no queuing.
- `tile_valid` outside REQ is ignored; a tile is never consumed outside the handshake.
- Address arithmetic is modulo 2^ADDR_WIDTH: 0xFFFFFF+1 wraps to 0x000000 with no error.
- `mem_we`, `mem_addr` and `mem_din` are registered outputs.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - state=IDLE.
  - `tile_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `busy`=0, `done`=0.
  - Internal counters and tile register are cleared.
- Reset asserted mid-operation aborts immediately: no further writes and no `done`. After release, the block is in IDLE.
- Start latency:
  - `valid_in` sampled at edge E; REQ (and `tile_ready`=1) from E+1.
  - Handshake at edge H; first `mem_we`=1 in the cycle after H, with `mem_addr`=base.
- Throughput: one byte per cycle inside a tile. Each additional tile costs one REQ cycle minimum, plus any `tile_valid` stall.
- Full 16-element store with `tile_valid` held high:
  - `valid_in` at cycle 0, REQ at 1, writes in cycles 2..17.
  - `done` at 18; IDLE and ready for a new `valid_in` at 19.
- `length`=0: `valid_in` at 0, `done` at 1, IDLE at 2.
- `done` and `mem_we` are never high in the same cycle.

## Configuration
- Macro `STORE_ZERO_PAD_EN`:
  - Defined: a partial final tile is still written as a full `TILE_ELEMS` bytes. Bytes beyond `length` are written as 0x00, and `remaining` saturates at 0.
  - Not defined: exactly `length` bytes are written, with no writes past base+`length`-1.
- The `length`=0 behaviour is identical in both builds.

## Test plan
- Full tile: `length`=16, base=0x000100, tile bytes 0x00..0x0F MSB-first, `tile_valid` held high. Required: 16 writes to 0x100..0x10F with data 0x00..0x0F on cycles 2..17, and `done` at cycle 18.
- Partial second tile: `length`=20, two tiles supplied. Required: 20 writes to base..base+19, one REQ cycle between the tiles, `done` once. With `STORE_ZERO_PAD_EN`: 32 writes, the last 12 of them 0x00.
- Zero length: `length`=0. Required: no `mem_we`, `tile_ready` never high, `done` at cycle 1.
- Backpressure: `tile_valid` held low for 3 REQ cycles, and `valid_in` pulsed again during WRITE. Required: `tile_ready` stays high, writes start the cycle after `tile_valid` rises, and the second `valid_in` has no effect.
- Wrap: base=0xFFFFF8, `length`=16. Required: writes to 0xFFFFF8..0xFFFFFF then 0x000000..0x000007.
- Reset mid-write: `reset_n` driven low after the 5th write of a 16-byte store. Required: `mem_we`=0 immediately, no `done`. After release, a fresh store of 16 bytes completes normally.
